// File: rtl/mgia_vram_pkg.sv
// Shared types and default geometry for the MGIA shared video RAM.
package mgia_vram_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 16;

    // Arbiter / acknowledge sequencing
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VACK,
        ST_CACK
    } state_t;

    // Port identity, used to remember which side was served last
    typedef enum logic {
        G_VID,
        G_CPU
    } grant_t;

endpackage

// File: rtl/mgia_vram_store.sv
// Single-port synchronous-read store with per-byte write enables.
// Written in the plain block-RAM template so it maps onto one RAM macro;
// the array is deliberately not reset.
module mgia_vram_store
    import mgia_vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW/8-1:0]   be,
    input  logic [DW-1:0]     di,
    output logic [DW-1:0]     dout
);

    localparam int SW = DW / 8;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] dout_q;

    // One access per enabled cycle: masked byte write, or registered read
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < SW; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= di[8*i +: 8];
                    end
                end
            end else begin
                dout_q <= mem[addr];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/mgia_shared_vram.sv
// Video RAM shared between the MGIA scan-out fetch port (read-only) and a
// CPU port (read/write, byte lanes). A two-way fair arbiter issues at most
// one storage access per cycle; the granted port is acknowledged in the
// following cycle, with its read data valid alongside the ack.
module mgia_shared_vram
    import mgia_vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [AW-1:0]     V_ADR_I,
    input  logic              V_CYC_I,
    input  logic              V_STB_I,
    output logic              V_ACK_O,
    output logic [DW-1:0]     V_DAT_O,
    input  logic [AW-1:0]     C_ADR_I,
    input  logic              C_CYC_I,
    input  logic              C_STB_I,
    input  logic              C_WE_I,
    input  logic [DW/8-1:0]   C_SEL_I,
    input  logic [DW-1:0]     C_DAT_I,
    output logic              C_ACK_O,
    output logic [DW-1:0]     C_DAT_O
);

    state_t        state_q, state_d;
    grant_t        last_q, last_d;
    logic          c_rd_q, c_rd_d;
    logic [DW-1:0] vid_dat_q, vid_dat_d;
    logic [DW-1:0] cpu_dat_q, cpu_dat_d;

    logic          v_req, c_req;
    logic          issue_v, issue_c;
    logic          st_en, st_we;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_dout;

    assign v_req = V_CYC_I & V_STB_I;
    assign c_req = C_CYC_I & C_STB_I;

    // Arbitration and sequencing: grant in IDLE, acknowledge for one cycle
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        issue_v = 1'b0;
        issue_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (v_req && (!c_req || last_q == G_CPU)) begin
                    issue_v = 1'b1;
                    state_d = ST_VACK;
                end else if (c_req) begin
                    issue_c = 1'b1;
                    state_d = ST_CACK;
                end
            end
            ST_VACK: begin
                last_d  = G_VID;
                state_d = ST_IDLE;
            end
            ST_CACK: begin
                last_d  = G_CPU;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Storage request and read-data holding. The RAM output is only trusted
    // in the ack cycle of its own port; otherwise each port shows its last
    // captured word. Reset blocks the enable so no write can land while
    // reset is asserted.
    always_comb begin
        st_en     = (issue_v | issue_c) & ~RST_I;
        st_we     = issue_c & C_WE_I;
        st_addr   = issue_c ? C_ADR_I : V_ADR_I;
        c_rd_d    = issue_c ? ~C_WE_I : c_rd_q;
        vid_dat_d = (state_q == ST_VACK) ? st_dout : vid_dat_q;
        cpu_dat_d = (state_q == ST_CACK && c_rd_q) ? st_dout : cpu_dat_q;
    end

    // Control and output-holding registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            last_q    <= G_CPU;
            c_rd_q    <= 1'b0;
            vid_dat_q <= '0;
            cpu_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            c_rd_q    <= c_rd_d;
            vid_dat_q <= vid_dat_d;
            cpu_dat_q <= cpu_dat_d;
        end
    end

    // Bus outputs: acks follow the live strobes so an abandoned cycle is never acked
    always_comb begin
        V_ACK_O = (state_q == ST_VACK) & v_req;
        C_ACK_O = (state_q == ST_CACK) & c_req;
        V_DAT_O = (state_q == ST_VACK) ? st_dout : vid_dat_q;
        C_DAT_O = (state_q == ST_CACK && c_rd_q) ? st_dout : cpu_dat_q;
    end

    mgia_vram_store #(
        .AW (AW),
        .DW (DW)
    ) u_store (
        .clk  (CLK_I),
        .en   (st_en),
        .we   (st_we),
        .addr (st_addr),
        .be   (C_SEL_I),
        .di   (C_DAT_I),
        .dout (st_dout)
    );

endmodule

// File: tb/tb_mgia_shared_vram.sv
// Bench for mgia_shared_vram: a transaction-level model of the shared RAM
// checked against the DUT every cycle, plus directed literal expectations.
module tb_mgia_shared_vram;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] v_adr = '0;
    logic          v_cyc = 1'b0, v_stb = 1'b0;
    logic          v_ack;
    logic [DW-1:0] v_dat;
    logic [AW-1:0] c_adr = '0;
    logic          c_cyc = 1'b0, c_stb = 1'b0, c_we = 1'b0;
    logic [1:0]    c_sel = '0;
    logic [DW-1:0] c_dati = '0;
    logic          c_ack;
    logic [DW-1:0] c_dato;

    // Second instance for the narrow/wide geometry
    logic [3:0]    s_adr = '0;
    logic          s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [3:0]    s_sel = '0;
    logic [31:0]   s_dati = '0;
    logic          s_ack, s_vack;
    logic [31:0]   s_dato, s_vdat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mgia_shared_vram #(.AW(AW), .DW(DW)) dut (
        .CLK_I(clk), .RST_I(rst),
        .V_ADR_I(v_adr), .V_CYC_I(v_cyc), .V_STB_I(v_stb),
        .V_ACK_O(v_ack), .V_DAT_O(v_dat),
        .C_ADR_I(c_adr), .C_CYC_I(c_cyc), .C_STB_I(c_stb), .C_WE_I(c_we),
        .C_SEL_I(c_sel), .C_DAT_I(c_dati),
        .C_ACK_O(c_ack), .C_DAT_O(c_dato)
    );

    mgia_shared_vram #(.AW(4), .DW(32)) dut2 (
        .CLK_I(clk), .RST_I(rst),
        .V_ADR_I(4'd0), .V_CYC_I(1'b0), .V_STB_I(1'b0),
        .V_ACK_O(s_vack), .V_DAT_O(s_vdat),
        .C_ADR_I(s_adr), .C_CYC_I(s_cyc), .C_STB_I(s_stb), .C_WE_I(s_we),
        .C_SEL_I(s_sel), .C_DAT_I(s_dati),
        .C_ACK_O(s_ack), .C_DAT_O(s_dato)
    );

    // Transaction model: a free cycle serves one requester (ties go to the
    // port not served most recently), the following cycle is its ack cycle.
    logic [DW-1:0] m_mem [2**AW];
    logic          m_busy, m_port_cpu, m_last_cpu;
    logic [DW-1:0] m_vdat, m_cdat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy     <= 1'b0;
            m_port_cpu <= 1'b0;
            m_last_cpu <= 1'b1;
            m_vdat     <= '0;
            m_cdat     <= '0;
        end else if (m_busy) begin
            m_busy <= 1'b0;
        end else if ((v_cyc && v_stb) || (c_cyc && c_stb)) begin
            m_busy <= 1'b1;
            if ((v_cyc && v_stb) && (!(c_cyc && c_stb) || m_last_cpu)) begin
                m_port_cpu <= 1'b0;
                m_last_cpu <= 1'b0;
                m_vdat     <= m_mem[v_adr];
            end else begin
                m_port_cpu <= 1'b1;
                m_last_cpu <= 1'b1;
                if (c_we) begin
                    for (int i = 0; i < DW/8; i++)
                        if (c_sel[i]) m_mem[c_adr][8*i +: 8] <= c_dati[8*i +: 8];
                end else begin
                    m_cdat <= m_mem[c_adr];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare the DUT with the model
    task automatic step();
        @(negedge clk);
        chk("model_v_ack", {31'd0, v_ack}, {31'd0, m_busy && !m_port_cpu && v_cyc && v_stb});
        chk("model_c_ack", {31'd0, c_ack}, {31'd0, m_busy &&  m_port_cpu && c_cyc && c_stb});
        chk("model_v_dat", {16'd0, v_dat}, {16'd0, m_vdat});
        chk("model_c_dat", {16'd0, c_dato}, {16'd0, m_cdat});
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_xfer(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                            input logic [1:0] sel, output logic [DW-1:0] rd);
        bit got = 0;
        c_adr = adr; c_we = we; c_dati = dat; c_sel = sel; c_cyc = 1'b1; c_stb = 1'b1;
        rd = 'x;
        for (int n = 0; n < 8 && !got; n++) begin
            step();
            if (c_ack) begin got = 1; rd = c_dato; end
        end
        if (!got) chk("cpu_ack_timeout", 32'd0, 32'd1);
        to_drive();
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0;
    endtask

    task automatic vid_read(input logic [AW-1:0] adr, output logic [DW-1:0] rd);
        bit got = 0;
        v_adr = adr; v_cyc = 1'b1; v_stb = 1'b1;
        rd = 'x;
        for (int n = 0; n < 8 && !got; n++) begin
            step();
            if (v_ack) begin got = 1; rd = v_dat; end
        end
        if (!got) chk("vid_ack_timeout", 32'd0, 32'd1);
        to_drive();
        v_cyc = 1'b0; v_stb = 1'b0;
    endtask

    task automatic wide_xfer(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rd);
        bit got = 0;
        s_adr = adr; s_we = we; s_dati = dat; s_sel = sel; s_cyc = 1'b1; s_stb = 1'b1;
        rd = 'x;
        for (int n = 0; n < 8 && !got; n++) begin
            step();
            if (s_ack) begin got = 1; rd = s_dato; end
        end
        if (!got) chk("wide_ack_timeout", 32'd0, 32'd1);
        to_drive();
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [31:0]   w;

        step();
        step();
        chk("rst_v_ack", {31'd0, v_ack}, 32'd0);
        chk("rst_c_ack", {31'd0, c_ack}, 32'd0);
        chk("rst_v_dat", {16'd0, v_dat}, 32'd0);
        chk("rst_c_dat", {16'd0, c_dato}, 32'd0);
        to_drive();
        rst = 1'b0;

        // Preload and uncontended video latency
        cpu_xfer(13'h0010, 1'b1, 16'hAAAA, 2'b11, d);
        v_adr = 13'h0010; v_cyc = 1'b1; v_stb = 1'b1;
        step();
        chk("lat_ack_n", {31'd0, v_ack}, 32'd0);
        step();
        chk("lat_ack_n1", {31'd0, v_ack}, 32'd1);
        chk("lat_dat_n1", {16'd0, v_dat}, 32'h0000_AAAA);
        to_drive();
        v_cyc = 1'b0; v_stb = 1'b0;
        step();
        chk("lat_ack_n2", {31'd0, v_ack}, 32'd0);
        chk("lat_dat_hold", {16'd0, v_dat}, 32'h0000_AAAA);
        to_drive();

        // Byte-lane writes at the top address
        cpu_xfer(13'h1FFF, 1'b1, 16'h5555, 2'b11, d);
        cpu_xfer(13'h1FFF, 1'b1, 16'h12C3, 2'b01, d);
        cpu_xfer(13'h1FFF, 1'b0, 16'h0000, 2'b00, d);
        chk("lane0_write", {16'd0, d}, 32'h0000_55C3);
        cpu_xfer(13'h1FFF, 1'b1, 16'hAB00, 2'b10, d);
        cpu_xfer(13'h1FFF, 1'b0, 16'h0000, 2'b00, d);
        chk("lane1_write", {16'd0, d}, 32'h0000_ABC3);
        cpu_xfer(13'h1FFF, 1'b1, 16'hFFFF, 2'b00, d);
        cpu_xfer(13'h1FFF, 1'b0, 16'h0000, 2'b00, d);
        chk("nosel_write", {16'd0, d}, 32'h0000_ABC3);

        // CPU write then video read of the same word
        cpu_xfer(13'h0020, 1'b1, 16'h1234, 2'b11, d);
        vid_read(13'h0020, d);
        chk("cross_port", {16'd0, d}, 32'h0000_1234);

        // Abandoned write: strobe dropped in the ack cycle
        c_adr = 13'h0100; c_dati = 16'hBEEF; c_sel = 2'b11; c_we = 1'b1;
        c_cyc = 1'b1; c_stb = 1'b1;
        step();
        to_drive();
        c_stb = 1'b0;
        step();
        chk("abandon_ack", {31'd0, c_ack}, 32'd0);
        to_drive();
        c_cyc = 1'b0; c_we = 1'b0;
        cpu_xfer(13'h0100, 1'b0, 16'h0000, 2'b00, d);
        chk("abandon_commit", {16'd0, d}, 32'h0000_BEEF);

        // Contention from reset: V, C, V, C
        rst = 1'b1;
        v_adr = 13'h0010; v_cyc = 1'b1; v_stb = 1'b1;
        c_adr = 13'h1FFF; c_we = 1'b0; c_cyc = 1'b1; c_stb = 1'b1;
        step();
        to_drive();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("cont_v_ack", {31'd0, v_ack}, {31'd0, (k % 4) == 1});
            chk("cont_c_ack", {31'd0, c_ack}, {31'd0, (k % 4) == 3});
            chk("cont_both", {31'd0, v_ack & c_ack}, 32'd0);
            if (k == 0) chk("cont_v_dat_rst", {16'd0, v_dat}, 32'd0);
            if (k == 1) chk("cont_v_dat", {16'd0, v_dat}, 32'h0000_AAAA);
            if (k == 3) chk("cont_c_dat", {16'd0, c_dato}, 32'h0000_ABC3);
        end
        to_drive();
        v_cyc = 1'b0; v_stb = 1'b0; c_cyc = 1'b0; c_stb = 1'b0;
        step();
        to_drive();

        // Reset asserted during a CPU read acknowledge
        c_adr = 13'h0010; c_we = 1'b0; c_cyc = 1'b1; c_stb = 1'b1;
        step();
        step();
        chk("mid_ack_before", {31'd0, c_ack}, 32'd1);
        chk("mid_dat_before", {16'd0, c_dato}, 32'h0000_AAAA);
        #1 rst = 1'b1;
        #1;
        chk("mid_ack_rst", {31'd0, c_ack}, 32'd0);
        chk("mid_c_dat_rst", {16'd0, c_dato}, 32'd0);
        chk("mid_v_dat_rst", {16'd0, v_dat}, 32'd0);
        to_drive();
        c_cyc = 1'b0; c_stb = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_idle", {30'd0, v_ack, c_ack}, 32'd0);
        to_drive();
        vid_read(13'h0010, d);
        chk("post_rst_read", {16'd0, d}, 32'h0000_AAAA);

        // AW=4, DW=32 instance: masked writes at both ends of the array
        wide_xfer(4'h0, 1'b1, 32'h1111_1111, 4'b1111, w);
        wide_xfer(4'hF, 1'b1, 32'h2222_2222, 4'b1111, w);
        wide_xfer(4'h0, 1'b1, 32'hAABB_CCDD, 4'b1010, w);
        wide_xfer(4'hF, 1'b1, 32'hAABB_CCDD, 4'b1010, w);
        wide_xfer(4'h0, 1'b0, 32'h0, 4'b0000, w);
        chk("wide_addr0", w, 32'hAA11_CC11);
        wide_xfer(4'hF, 1'b0, 32'h0, 4'b0000, w);
        chk("wide_addr15", w, 32'hAA22_CC22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mgia_shared_vram.md
# mgia_shared_vram

Parametrised video RAM for the MGIA display path. Single-ported storage, two Wishbone classic slave ports: a read-only video-fetch port (V_) for the MGIA scan-out engine and a read/write CPU port (C_) with byte lanes, so software can draw into the frame buffer instead of relying only on power-up contents. A fair two-way arbiter serialises accesses: one storage access per cycle, one-cycle-registered acknowledge.

## Interface
- AW, 13, word address width; depth 2**AW words; AW >= 1
- DW, 16, data width; multiple of 8; SW = DW/8 byte lanes
- CLK_I  in  1  clock, all logic on rising edge
- RST_I  in  1  reset, asynchronous, active-high
- V_ADR_I  in  AW  video word address
- V_CYC_I, V_STB_I  in  1 each  video bus cycle / strobe
- V_ACK_O  out  1  video acknowledge
- V_DAT_O  out  DW  video read data
- C_ADR_I  in  AW  CPU word address
- C_CYC_I, C_STB_I, C_WE_I  in  1 each  CPU cycle / strobe / write enable
- C_SEL_I  in  SW  CPU byte selects; lane i = bits [8i+7:8i]
- C_DAT_I  in  DW  CPU write data
- C_ACK_O  out  1  CPU acknowledge
- C_DAT_O  out  DW  CPU read data

## Operation
- Request: V_REQ = V_CYC_I & V_STB_I; C_REQ = C_CYC_I & C_STB_I.
- FSM states: IDLE, VACK, CACK. Reset state IDLE.
- IDLE: if only V_REQ -> issue video read, go VACK. If only C_REQ -> issue CPU access, go CACK. If both -> grant the port not granted last (register `last`, reset value CPU, so video wins the first tie). Neither -> stay IDLE.
- VACK / CACK: last := granted port; always return to IDLE next cycle. No access issued in ACK states (STB still shows the completed request).
- Video read issue edge: V_DAT_O <= mem[V_ADR_I].
- CPU read issue edge (C_WE_I=0): C_DAT_O <= mem[C_ADR_I].
- CPU write issue edge (C_WE_I=1): for each lane i with C_SEL_I[i]=1, mem[C_ADR_I] lane i <= C_DAT_I lane i; other lanes unchanged; C_DAT_O unchanged. C_SEL_I=0 is a legal no-op write, still acknowledged.
- Acks: V_ACK_O = (state==VACK) & V_REQ; C_ACK_O = (state==CACK) & C_REQ. Master dropping STB/CYC during ACK state suppresses ack; an issued write has already committed.
- V_DAT_O / C_DAT_O hold last value until the next read on their own port.
- Storage contents are not affected by reset; initial contents are a synthesis-time initialisation of the store.

## Timing
- Reset (async assert, sync-released use): state IDLE, last CPU, V_ACK_O 0, C_ACK_O 0, V_DAT_O 0, C_DAT_O 0.
- Uncontended latency: request seen in cycle n (IDLE) -> ack high in cycle n+1; data valid in same cycle as ack.
- Throughput: one access per 2 cycles total; contended steady state alternates V, C, V, C (4 cycles per pair).
- Worst-case wait for a continuously requesting port: 2 cycles before issue.
- Reset mid-access: ack dropped immediately; write either fully committed (issue edge passed) or not at all; no partial-lane write.
- Same-address write then read on other port: read issued after the write returns new data (no bypass needed since accesses are serialised).

## Structure
- Package mgia_vram_pkg: state enum (ST_IDLE, ST_VACK, ST_CACK), grant enum (G_VID, G_CPU), default AW/DW constants.
- Sub-module mgia_vram_store: single-port 2**AW x DW array, sync read, per-byte write enable, ADDR/WE/BE/DI/DO; maps to block RAM. Top level holds FSM, arbiter, output registers.

## Test plan
- Reset: assert RST_I mid-CACK -> C_ACK_O falls same cycle; all outputs 0; state IDLE after release.
- Uncontended video read: preload mem[0x0010]=0xAAAA, V request at cycle n -> V_ACK_O=1 at n+1, V_DAT_O=0xAAAA, ack 0 at n+2.
- Byte write: mem[0x1FFF]=0x5555, CPU write 0x12C3 with C_SEL_I=2'b01 -> CPU read back 0x55C3; C_SEL_I=2'b10 write 0xAB00 -> 0xAB C3 read as 0xABC3.
- Contention: both ports request continuously from reset -> grants V, C, V, C; each ack exactly one cycle, never both high together.
- Abandoned cycle: CPU drops STB during CACK of write 0xBEEF to 0x0100 -> C_ACK_O stays 0; subsequent read of 0x0100 returns 0xBEEF.
- Parameter sweep: AW=4, DW=32 -> writes to addresses 0 and 15 with C_SEL_I=4'b1010 update only lanes 1 and 3.
